// File: rtl/vga_timing.sv
// Free-running VGA raster generator: pixel-rate divider, x/y counters, one-clk-delayed
// active-low syncs, frame-start strobe and a slow animation step counter.
`ifndef MAX_ANIMATION_FRAME_LOG2
`define MAX_ANIMATION_FRAME_LOG2 4
`endif

module vga_timing #(
    parameter int CLK_DIV     = 4,
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int ANIM_FRAMES = 15
) (
    input  logic                                 clk,
    input  logic                                 rst,
    output logic [9:0]                           x,
    output logic [9:0]                           y,
    output logic                                 toDisplay,
    output logic                                 hsync,
    output logic                                 vsync,
    output logic                                 pixel_tick,
    output logic                                 frame_start,
    output logic [`MAX_ANIMATION_FRAME_LOG2-1:0] animation_timer
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FRAME_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam int ANIM_W  = `MAX_ANIMATION_FRAME_LOG2;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(ANIM_FRAMES - 1);

    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_frame_start;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [ANIM_W-1:0]  r_anim;

    logic w_pixel_tick;
    logic w_x_last;
    logic w_y_last;
    logic w_frame_wrap;

    // With a divide of 1 every clk is a pixel, so no divider register exists at all.
    generate
        if (CLK_DIV == 1) begin : g_no_div
            assign w_pixel_tick = 1'b1;
        end else begin : g_div
            localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
            logic [DIV_W-1:0] r_div;

            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values; reset is asynchronous and clears without a clk.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_div <= '0;
                end else if (r_div == DIV_LAST) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end

            assign w_pixel_tick = (r_div == DIV_LAST);
        end
    endgenerate

    assign w_x_last     = (r_x == H_LAST);
    assign w_y_last     = (r_y == V_LAST);
    assign w_frame_wrap = w_pixel_tick && w_x_last && w_y_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_pixel_tick) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    // Syncs lag the counters by one clk to line up with the renderer's registered colour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= !((r_x >= H_SYNC_START) && (r_x < H_SYNC_END));
            r_vsync       <= !((r_y >= V_SYNC_START) && (r_y < V_SYNC_END));
            r_frame_start <= w_frame_wrap;
        end
    end

    // Frame counter advances on the same edge that raises frame_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_anim      <= '0;
        end else if (w_frame_wrap) begin
            if (r_frame_cnt == FRAME_LAST) begin
                r_frame_cnt <= '0;
                r_anim      <= r_anim + 1'b1;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign x               = r_x;
    assign y               = r_y;
    assign toDisplay       = (r_x < H_VIS_END) && (r_y < V_VIS_END);
    assign hsync           = r_hsync;
    assign vsync           = r_vsync;
    assign pixel_tick      = w_pixel_tick;
    assign frame_start     = r_frame_start;
    assign animation_timer = r_anim;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: a closed-form raster model predicts every output
// from the number of clk edges since reset release, for three parameter sets.
`ifndef MAX_ANIMATION_FRAME_LOG2
`define MAX_ANIMATION_FRAME_LOG2 4
`endif

module tb_vga_timing;

    localparam int W = `MAX_ANIMATION_FRAME_LOG2;
    typedef logic [W+24:0] obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n = 0;
    int   checks = 0;
    int   errors = 0;

    obs_t q_a[$];
    obs_t q_b[$];
    obs_t q_c[$];

    logic [9:0]   a_x, a_y, b_x, b_y, c_x, c_y;
    logic         a_td, a_hs, a_vs, a_pt, a_fs;
    logic         b_td, b_hs, b_vs, b_pt, b_fs;
    logic         c_td, c_hs, c_vs, c_pt, c_fs;
    logic [W-1:0] a_an, b_an, c_an;

    always #5 clk = ~clk;

    // Small raster (16x11), divide by 4, three frames per animation step.
    vga_timing #(.CLK_DIV(4), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                 .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .ANIM_FRAMES(3)) u_a (
        .clk(clk), .rst(rst), .x(a_x), .y(a_y), .toDisplay(a_td), .hsync(a_hs),
        .vsync(a_vs), .pixel_tick(a_pt), .frame_start(a_fs), .animation_timer(a_an));

    // Same raster at one pixel per clk.
    vga_timing #(.CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                 .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .ANIM_FRAMES(2)) u_b (
        .clk(clk), .rst(rst), .x(b_x), .y(b_y), .toDisplay(b_td), .hsync(b_hs),
        .vsync(b_vs), .pixel_tick(b_pt), .frame_start(b_fs), .animation_timer(b_an));

    // Standard 640x480 timing.
    vga_timing u_c (
        .clk(clk), .rst(rst), .x(c_x), .y(c_y), .toDisplay(c_td), .hsync(c_hs),
        .vsync(c_vs), .pixel_tick(c_pt), .frame_start(c_fs), .animation_timer(c_an));

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, act, exp, n);
        end
    endtask

    // Outputs after k clk edges since release: k/cd pixel ticks have elapsed.
    function automatic obs_t model(int k, int cd, int hv, int hfp, int hsw, int hbp,
                                   int vv, int vfp, int vsw, int vbp, int anim);
        int   ht, vt, ft, t, px, py, tp, xp, yp, am;
        logic hs, vs, pt, fs, td;
        ht = hv + hfp + hsw + hbp;
        vt = vv + vfp + vsw + vbp;
        ft = ht * vt;
        t  = k / cd;
        px = t % ht;
        py = (t / ht) % vt;
        hs = 1'b1;
        vs = 1'b1;
        if (k > 0) begin
            tp = (k - 1) / cd;
            xp = tp % ht;
            yp = (tp / ht) % vt;
            hs = !(xp >= hv + hfp && xp < hv + hfp + hsw);
            vs = !(yp >= vv + vfp && yp < vv + vfp + vsw);
        end
        td = (px < hv) && (py < vv);
        pt = ((k % cd) == cd - 1);
        fs = (k > 0) && ((k % cd) == 0) && ((t % ft) == 0);
        am = ((t / ft) / anim) % (1 << W);
        return {W'(am), fs, pt, vs, hs, td, 10'(py), 10'(px)};
    endfunction

    function automatic obs_t model_a(int k);
        return model(k, 4, 8, 2, 3, 3, 6, 1, 2, 2, 3);
    endfunction
    function automatic obs_t model_b(int k);
        return model(k, 1, 8, 2, 3, 3, 6, 1, 2, 2, 2);
    endfunction
    function automatic obs_t model_c(int k);
        return model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33, 15);
    endfunction

    // Stimulus side: each edge advances the model and queues the expected outputs.
    always @(posedge clk) begin
        if (rst) n = 0;
        else     n = n + 1;
        q_a.push_back(model_a(n));
        q_b.push_back(model_b(n));
        q_c.push_back(model_c(n));
    end

    // Response side: compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (q_a.size() > 0) check("obs_a", {a_an, a_fs, a_pt, a_vs, a_hs, a_td, a_y, a_x}, q_a.pop_front());
        if (q_b.size() > 0) check("obs_b", {b_an, b_fs, b_pt, b_vs, b_hs, b_td, b_y, b_x}, q_b.pop_front());
        if (q_c.size() > 0) check("obs_c", {c_an, c_fs, c_pt, c_vs, c_hs, c_td, c_y, c_x}, q_c.pop_front());
    end

    task automatic check_after_release();
        repeat (3) @(posedge clk);
        #1;
        check("a_x_edge3", a_x, 10'd0);
        check("a_tick_edge3", a_pt, 1'b1);
        @(posedge clk);
        #1;
        check("a_x_edge4", a_x, 10'd1);
        check("c_x_edge4", c_x, 10'd1);
        check("c_y_edge4", c_y, 10'd0);
        check("b_x_edge4", b_x, 10'd4);
        check("a_fs_edge4", a_fs, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("a_x_edge8", a_x, 10'd2);
        check("c_x_edge8", c_x, 10'd2);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_a", {a_an, a_fs, a_pt, a_vs, a_hs, a_td, a_y, a_x}, model_a(0));
        check("rst_c", {c_an, c_fs, c_pt, c_vs, c_hs, c_td, c_y, c_x}, model_c(0));
        rst = 1'b0;
        check_after_release();

        // Long enough for the small raster's animation counter to wrap.
        repeat (34500) @(posedge clk);

        // Asynchronous reset mid-frame, between clk edges.
        @(negedge clk);
        #1;
        check("a_pre_rst_busy", (a_x != 10'd0 || a_y != 10'd0), 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_a", {a_an, a_fs, a_pt, a_vs, a_hs, a_td, a_y, a_x}, model_a(0));
        check("async_rst_b", {b_an, b_fs, b_pt, b_vs, b_hs, b_td, b_y, b_x}, model_b(0));
        check("async_rst_c", {c_an, c_fs, c_pt, c_vs, c_hs, c_td, c_y, c_x}, model_c(0));
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        check_after_release();

        // Covers at least one full standard-timing line after the second reset.
        repeat (4000) @(posedge clk);
        @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
